// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Optional feature macro: PLL_SEQ_LOSS_COUNT_EN (loss-of-lock event counter).
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } seq_state_e;

  localparam int LOSS_COUNT_W = 8;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold 0..max_retries.
  function automatic int retry_w(input int max_retries);
    return cnt_w(max_retries + 1);
  endfunction

  // Saturating increment for the loss-of-lock counter.
  function automatic logic [LOSS_COUNT_W-1:0] sat_inc(input logic [LOSS_COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Status/control bundle between the PLL reset sequencer and its surroundings.
// Optional feature macro: PLL_SEQ_LOSS_COUNT_EN adds the loss_count signal.
interface pll_reset_sequencer_if
  import pll_seq_pkg::*;
#(
  parameter int MAX_RETRIES = 3
);

  localparam int RETRY_W = retry_w(MAX_RETRIES);

  logic               pll_locked;  // raw PLL lock, asynchronous to refclk
  logic               soft_reset;  // level request to restart sequencing
  logic               pll_rst;     // drives the PLL reset input
  logic               sys_rst;     // downstream active-high reset
  logic               ready;       // high only in RUN
  logic               fault;       // high only in FAULT
  logic [RETRY_W-1:0] retry_cnt;   // retries used in the current sequence
`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [LOSS_COUNT_W-1:0] loss_count;  // RUN -> RESET_PLL loss events
`endif

  // Sequencer side.
  modport master (
    input  pll_locked,
    input  soft_reset,
    output pll_rst,
    output sys_rst,
    output ready,
    output fault,
    output retry_cnt
`ifdef PLL_SEQ_LOSS_COUNT_EN
    , output loss_count
`endif
  );

  // PLL wrapper / system side.
  modport slave (
    output pll_locked,
    output soft_reset,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  fault,
    input  retry_cnt
`ifdef PLL_SEQ_LOSS_COUNT_EN
    , input  loss_count
`endif
  );

endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic two-flop synchroniser with asynchronous active-high reset.
// Optional feature macro PLL_SEQ_LOSS_COUNT_EN has no effect here.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous input; both stages clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking so each stage takes the other's pre-edge value;
      // blocking here would collapse the chain into a single flop.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the system reset. Retries on lock timeout, faults after the retry
// budget, and re-sequences on loss of lock.
// Optional feature macro: PLL_SEQ_LOSS_COUNT_EN (saturating loss-of-lock count).
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                   refclk,
  input  logic                   rst,
  pll_reset_sequencer_if.master  bus
);

  localparam int PULSE_W   = cnt_w(RST_PULSE_CYCLES);
  localparam int TIMEOUT_W = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int STABLE_W  = cnt_w(LOCK_STABLE_CYCLES);
  localparam int RETRY_W   = retry_w(MAX_RETRIES);

  localparam logic [PULSE_W-1:0]   PULSE_LAST   = PULSE_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STABLE_W-1:0]  STABLE_LAST  = STABLE_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0]   RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  logic                 locked_s;
  seq_state_e           state_q;
  logic [PULSE_W-1:0]   pulse_cnt_q;
  logic [TIMEOUT_W-1:0] timeout_cnt_q;
  logic [STABLE_W-1:0]  stable_cnt_q;
  logic [RETRY_W-1:0]   retry_cnt_q;
  logic                 pll_rst_q;
  logic                 sys_rst_q;
  logic                 ready_q;
  logic                 fault_q;
`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic [LOSS_COUNT_W-1:0] loss_count_q;
`endif

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d_i (bus.pll_locked),
    .q_o (locked_s)
  );

  // Sequencing FSM with its counters and registered outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q       <= RESET_PLL;
      pulse_cnt_q   <= '0;
      timeout_cnt_q <= '0;
      stable_cnt_q  <= '0;
      retry_cnt_q   <= '0;
      pll_rst_q     <= 1'b1;
      sys_rst_q     <= 1'b1;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
`ifdef PLL_SEQ_LOSS_COUNT_EN
      loss_count_q  <= '0;
`endif
    end else if (bus.soft_reset) begin
      // Restart request outranks every state event; the pulse counter is
      // held at zero for as long as the request stays high.
      state_q       <= RESET_PLL;
      pulse_cnt_q   <= '0;
      timeout_cnt_q <= '0;
      stable_cnt_q  <= '0;
      retry_cnt_q   <= '0;
      pll_rst_q     <= 1'b1;
      sys_rst_q     <= 1'b1;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      // NOTE: outputs are assigned together with the state they belong to,
      // so they are plain flops that change on the same edge as state_q.
      case (state_q)
        RESET_PLL: begin
          if (pulse_cnt_q == PULSE_LAST) begin
            state_q       <= WAIT_LOCK;
            pulse_cnt_q   <= '0;
            timeout_cnt_q <= '0;
            pll_rst_q     <= 1'b0;
          end else begin
            pulse_cnt_q <= pulse_cnt_q + 1'b1;
          end
        end

        WAIT_LOCK: begin
          if (locked_s) begin
            // Lock wins over a coincident timeout.
            state_q       <= STABLE;
            stable_cnt_q  <= '0;
            timeout_cnt_q <= '0;
          end else if (timeout_cnt_q == TIMEOUT_LAST) begin
            timeout_cnt_q <= '0;
            pll_rst_q     <= 1'b1;
            if (retry_cnt_q < RETRY_MAX) begin
              state_q     <= RESET_PLL;
              pulse_cnt_q <= '0;
              retry_cnt_q <= retry_cnt_q + 1'b1;
            end else begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end
          end else begin
            timeout_cnt_q <= timeout_cnt_q + 1'b1;
          end
        end

        STABLE: begin
          if (!locked_s) begin
            // Lock glitch: wait again without spending a retry.
            state_q       <= WAIT_LOCK;
            timeout_cnt_q <= '0;
            stable_cnt_q  <= '0;
          end else if (stable_cnt_q == STABLE_LAST) begin
            state_q      <= RUN;
            stable_cnt_q <= '0;
            sys_rst_q    <= 1'b0;
            ready_q      <= 1'b1;
          end else begin
            stable_cnt_q <= stable_cnt_q + 1'b1;
          end
        end

        RUN: begin
          if (!locked_s) begin
            state_q     <= RESET_PLL;
            pulse_cnt_q <= '0;
            retry_cnt_q <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
`ifdef PLL_SEQ_LOSS_COUNT_EN
            loss_count_q <= sat_inc(loss_count_q);
`endif
          end
        end

        FAULT: begin
          // Terminal: only rst or soft_reset leave this state.
          pll_rst_q <= 1'b1;
          sys_rst_q <= 1'b1;
          ready_q   <= 1'b0;
          fault_q   <= 1'b1;
        end

        default: begin
          state_q       <= RESET_PLL;
          pulse_cnt_q   <= '0;
          timeout_cnt_q <= '0;
          stable_cnt_q  <= '0;
          retry_cnt_q   <= '0;
          pll_rst_q     <= 1'b1;
          sys_rst_q     <= 1'b1;
          ready_q       <= 1'b0;
          fault_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = retry_cnt_q;
`ifdef PLL_SEQ_LOSS_COUNT_EN
  assign bus.loss_count = loss_count_q;
`endif

endmodule
